// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// busy/done status and the registered {c,s} result out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c;

  // Handshake: start is taken on a rising edge only while the adder is idle
  // or in its done cycle; busy marks the cycles where start is ignored, and
  // done is a one-cycle pulse during which s/c hold the fresh result.
  modport master (
    output start, a, b, cin,
    input  busy, done, s, c
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, c
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage plus a carry flop processes one
// operand bit per cycle, LSB first, and publishes {c,s} on completion.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus,
  output logic [1:0]    state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             k_q, k_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             last_bit;
  logic             fa_s;
  logic             fa_k;
  logic [WIDTH-1:0] sum_shift;

  assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Single full-adder stage on the current LSBs and the running carry.
  assign fa_s = a_q[0] ^ b_q[0] ^ k_q;
  assign fa_k = (a_q[0] & b_q[0]) | (k_q & (a_q[0] ^ b_q[0]));

  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_s;
    end else begin : g_sum_wn
      assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
  end

  assign bus.s   = s_q;
  assign bus.c   = c_q;
  assign state_o = state_q;

  // Datapath next values; s/c move only on the edge that finishes the last bit.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    sum_d = sum_q;
    k_d   = k_q;
    cnt_d = cnt_q;
    s_d   = s_q;
    c_d   = c_q;
    if (accept) begin
      a_d   = bus.a;
      b_d   = bus.b;
      k_d   = bus.cin;
      sum_d = '0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      sum_d = sum_shift;
      k_d   = fa_k;
      cnt_d = cnt_q + CW'(1);
      if (last_bit) begin
        s_d = sum_shift;
        c_d = fa_k;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      k_q   <= 1'b0;
      cnt_q <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      k_q   <= k_d;
      cnt_q <= cnt_d;
      s_q   <= s_d;
      c_q   <= c_d;
    end
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to add the operands presented this cycle.
REQ-005 a  input  WIDTH  operand A, sampled only when start is accepted.
REQ-006 b  input  WIDTH  operand B, sampled only when start is accepted.
REQ-007 cin  input  1  carry-in, sampled only when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking s and c valid.
REQ-010 s  output  WIDTH  sum of the last completed addition.
REQ-011 c  output  1  carry-out of the last completed addition.

Function
REQ-012 The block SHALL compute {c,s} = a + b + cin bit-serially, LSB first, using one single-bit full-adder stage (s_i = a_i^b_i^k, k' = a_i&b_i | k&(a_i^b_i)) plus a carry flip-flop k.
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; the reset state is IDLE.
REQ-014 start SHALL be accepted only in IDLE or DONE; acceptance latches a, b and cin into shift/carry registers, clears the bit counter and enters RUN.
REQ-015 In RUN, the block SHALL process exactly one bit per cycle: shift the operand registers right by one, shift the sum bit into the MSB of an internal sum shift register, update k, and increment the counter.
REQ-016 After the edge that processes bit WIDTH-1, the FSM SHALL enter DONE, copy the internal sum register to s and k to c, and assert done for exactly that one cycle.
REQ-017 Latency: with start sampled high at edge E0, done SHALL be high in the cycle following edge E_WIDTH (WIDTH cycles later); for WIDTH=1, the cycle after E1.
REQ-018 From DONE, the FSM SHALL return to IDLE on the next edge unless start is high, in which case it SHALL accept the new operation (back-to-back, no idle bubble).
REQ-019 busy SHALL be high exactly in RUN; start while busy SHALL be ignored with no effect on the operation in progress.
REQ-020 s and c SHALL change only on the DONE-entry edge and otherwise hold their last value, including throughout RUN and IDLE.
REQ-021 Carry-out SHALL be the (WIDTH+1)-th bit of the sum; no overflow is discarded other than into c.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL not wrap during an operation.

Reset
REQ-023 rst_n low SHALL asynchronously force state to IDLE and busy=0, done=0, s=0, c=0, clearing the counter, the carry flip-flop and all internal registers.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and s and c SHALL read 0.
REQ-025 After rst_n deasserts, the first rising edge with start high SHALL be accepted normally.

Verification (WIDTH=8 unless stated)
REQ-026 Exhaustive WIDTH=1: all 8 combinations of a,b,cin -> {c,s} equal to the full-adder truth table, done one cycle after start.
REQ-027 a=0xFF, b=0x01, cin=0 -> done 8 cycles after start, s=0x00, c=1; busy high for exactly 8 cycles.
REQ-028 a=0x5A, b=0xA5, cin=1 -> s=0x00, c=1; a=0x12, b=0x34, cin=0 -> s=0x46, c=0.
REQ-029 start held high continuously with new operands on each DONE cycle -> consecutive done pulses exactly 9 cycles apart, each result correct; operand changes during RUN have no effect.
REQ-030 rst_n pulsed low at RUN cycle 4 of a=0xFF, b=0xFF -> busy, done, s, c immediately 0; no done pulse; next start yields s=0xFE, c=1.
REQ-031 Random operands and cin over 1000 operations, compared against a reference a+b+cin -> zero mismatches; s and c stable between done pulses.
